// File: rtl/memory_stage_if.sv
// memory_stage_if: request/acknowledge data-memory bus between the MEM stage
// (master) and the data memory (slave).
interface memory_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage. Owns the data-memory req/ack handshake,
// builds byte enables and lane-replicated store data, extracts and extends
// load data, stalls upstream while a transaction is outstanding and feeds
// the MEM/WB registers.
// Optional feature: define MEM_STAGE_TIMEOUT_EN to abort a transaction after
// TIMEOUT_CYCLES wait-state cycles and pulse bus_error_out.
module memory_stage #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         rd_addr_in,
    input  logic               reg_write_in,
    input  logic               mem_write_in,
    input  logic [31:0]        alu_result_in,
    input  logic [31:0]        rs2_in,
    input  logic [1:0]         wb_mux_in,
    input  logic [2:0]         mem_size_in,
    memory_stage_if.master     dmem,
    output logic               stall,
    output logic [31:0]        forward_mem,
    output logic [4:0]         rd_addr_out,
    output logic               reg_write_out,
    output logic [31:0]        alu_result_out,
    output logic [31:0]        mem_rdata_out,
    output logic [1:0]         wb_mux_out,
    output logic               misaligned_out,
    output logic               bus_error_out
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t      state_q, state_d;
    logic [4:0]  rdAddr_q;
    logic        regWrite_q;
    logic [31:0] aluResult_q;
    logic [31:0] memRdata_q;
    logic [1:0]  wbMux_q;
    logic        misaligned_q;

    logic        memOp, isLoad, sizeIllegal, misalignRaw, misalign;
    logic        timeoutHit, req;
    logic [3:0]  beRaw;
    logic [31:0] wdataRaw, loadShift, loadExt;

    assign memOp       = mem_write_in | (wb_mux_in == 2'b01);
    assign isLoad      = ~mem_write_in & (wb_mux_in == 2'b01);
    assign forward_mem = alu_result_in;

    // Alignment check per access size; unknown funct3 codes count as misaligned
    always_comb begin
        sizeIllegal = 1'b0;
        misalignRaw = 1'b0;
        case (mem_size_in)
            3'b000, 3'b100: misalignRaw = 1'b0;
            3'b001, 3'b101: misalignRaw = alu_result_in[0];
            3'b010:         misalignRaw = |alu_result_in[1:0];
            default:        sizeIllegal = 1'b1;
        endcase
    end

    assign misalign = memOp & (misalignRaw | sizeIllegal);

`ifdef MEM_STAGE_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] waitCnt_q, waitCnt_d;
    logic                 busError_q;

    assign timeoutHit    = (state_q == ST_WAIT) && (waitCnt_q == TIMEOUT_W'(TIMEOUT_CYCLES));
    assign bus_error_out = busError_q;
`else
    logic unusedParams;

    assign timeoutHit    = 1'b0;
    assign bus_error_out = 1'b0;
    assign unusedParams  = ^{32'(TIMEOUT_CYCLES), 32'(TIMEOUT_W)};
`endif

    // Request is held for the whole WAIT phase; reset kills it in the same cycle
    assign req = ~rst & ~timeoutHit &
                 ((state_q == ST_WAIT) | ((state_q == ST_IDLE) & memOp & ~misalign));
    assign stall = req & ~dmem.dmem_ack;

    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = req & mem_write_in;
    assign dmem.dmem_addr  = {alu_result_in[31:2], 2'b00};
    assign dmem.dmem_be    = req ? beRaw : 4'b0000;
    assign dmem.dmem_wdata = wdataRaw;

    // Byte enables and store-data lane replication from size and address
    always_comb begin
        beRaw    = 4'b1111;
        wdataRaw = rs2_in;
        case (mem_size_in[1:0])
            2'b00: begin
                beRaw    = 4'b0001 << alu_result_in[1:0];
                wdataRaw = {4{rs2_in[7:0]}};
            end
            2'b01: begin
                beRaw    = 4'b0011 << {alu_result_in[1], 1'b0};
                wdataRaw = {2{rs2_in[15:0]}};
            end
            default: begin
                beRaw    = 4'b1111;
                wdataRaw = rs2_in;
            end
        endcase
    end

    // Load data: shift the addressed lane down, then sign- or zero-extend
    always_comb begin
        loadShift = dmem.dmem_rdata >> {alu_result_in[1:0], 3'b000};
        case (mem_size_in)
            3'b000:  loadExt = {{24{loadShift[7]}}, loadShift[7:0]};
            3'b001:  loadExt = {{16{loadShift[15]}}, loadShift[15:0]};
            3'b100:  loadExt = {24'h000000, loadShift[7:0]};
            3'b101:  loadExt = {16'h0000, loadShift[15:0]};
            default: loadExt = loadShift;
        endcase
    end

    // Next-state logic: stay in WAIT while a request is unanswered
    always_comb begin
        state_d = (req & ~dmem.dmem_ack) ? ST_WAIT : ST_IDLE;
`ifdef MEM_STAGE_TIMEOUT_EN
        waitCnt_d = ((state_q == ST_WAIT) && !dmem.dmem_ack) ? waitCnt_q + TIMEOUT_W'(1) : '0;
`endif
    end

    // FSM state plus MEM/WB registers; a stalled cycle loads a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rdAddr_q     <= '0;
            regWrite_q   <= 1'b0;
            aluResult_q  <= '0;
            memRdata_q   <= '0;
            wbMux_q      <= '0;
            misaligned_q <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
            waitCnt_q    <= '0;
            busError_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            misaligned_q <= misalign & (state_q == ST_IDLE);
`ifdef MEM_STAGE_TIMEOUT_EN
            waitCnt_q    <= waitCnt_d;
            busError_q   <= timeoutHit;
`endif
            if (stall) begin
                rdAddr_q    <= '0;
                regWrite_q  <= 1'b0;
                aluResult_q <= '0;
                memRdata_q  <= '0;
                wbMux_q     <= 2'b00;
            end else begin
                rdAddr_q    <= rd_addr_in;
                regWrite_q  <= reg_write_in & ~misalign & ~timeoutHit;
                aluResult_q <= alu_result_in;
                memRdata_q  <= (isLoad & req & dmem.dmem_ack) ? loadExt : 32'h0;
                wbMux_q     <= wb_mux_in;
            end
        end
    end

    assign rd_addr_out    = rdAddr_q;
    assign reg_write_out  = regWrite_q;
    assign alu_result_out = aluResult_q;
    assign mem_rdata_out  = memRdata_q;
    assign wb_mux_out     = wbMux_q;
    assign misaligned_out = misaligned_q;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed, table-driven bench for memory_stage, plus
// hand-written sequences for wait states, reset abort and stalled requests.
module tb_memory_stage;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        mw;
        logic [1:0]  wb;
        logic [2:0]  size;
        logic        ack;
        logic [31:0] rdata;
        logic        expReq;
        logic        expWe;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic        expStall;
        logic        expRw;
        logic [4:0]  expRd;
        logic [31:0] expAlu;
        logic [31:0] expRdata;
        logic [1:0]  expWb;
        logic        expMis;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [4:0]  rd_addr_in;
    logic        reg_write_in;
    logic        mem_write_in;
    logic [31:0] alu_result_in;
    logic [31:0] rs2_in;
    logic [1:0]  wb_mux_in;
    logic [2:0]  mem_size_in;
    logic        stall;
    logic [31:0] forward_mem;
    logic [4:0]  rd_addr_out;
    logic        reg_write_out;
    logic [31:0] alu_result_out;
    logic [31:0] mem_rdata_out;
    logic [1:0]  wb_mux_out;
    logic        misaligned_out;
    logic        bus_error_out;

    int cmpCount = 0;
    int errCount = 0;

    vec_t vecs[14];
    vec_t v;

    memory_stage_if dmemBus ();

    memory_stage #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .rd_addr_in     (rd_addr_in),
        .reg_write_in   (reg_write_in),
        .mem_write_in   (mem_write_in),
        .alu_result_in  (alu_result_in),
        .rs2_in         (rs2_in),
        .wb_mux_in      (wb_mux_in),
        .mem_size_in    (mem_size_in),
        .dmem           (dmemBus.master),
        .stall          (stall),
        .forward_mem    (forward_mem),
        .rd_addr_out    (rd_addr_out),
        .reg_write_out  (reg_write_out),
        .alu_result_out (alu_result_out),
        .mem_rdata_out  (mem_rdata_out),
        .wb_mux_out     (wb_mux_out),
        .misaligned_out (misaligned_out),
        .bus_error_out  (bus_error_out)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global guard so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired: actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmpCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t s);
        alu_result_in      = s.alu;
        rs2_in             = s.rs2;
        rd_addr_in         = s.rd;
        reg_write_in       = s.rw;
        mem_write_in       = s.mw;
        wb_mux_in          = s.wb;
        mem_size_in        = s.size;
        dmemBus.dmem_ack   = s.ack;
        dmemBus.dmem_rdata = s.rdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkRegsZero(input string tag);
        checkOutput({tag, "_rw"},   32'(reg_write_out), 32'h0);
        checkOutput({tag, "_rd"},   32'(rd_addr_out), 32'h0);
        checkOutput({tag, "_alu"},  alu_result_out, 32'h0);
        checkOutput({tag, "_rdat"}, mem_rdata_out, 32'h0);
        checkOutput({tag, "_wb"},   32'(wb_mux_out), 32'h0);
        checkOutput({tag, "_mis"},  32'(misaligned_out), 32'h0);
        checkOutput({tag, "_berr"}, 32'(bus_error_out), 32'h0);
    endtask

    function automatic vec_t mkOp(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                                  input logic rw, input logic mw, input logic [1:0] wb,
                                  input logic [2:0] size, input logic ack, input logic [31:0] rdata);
        vec_t r;
        r          = '{default: '0};
        r.alu      = alu;
        r.rs2      = rs2;
        r.rd       = rd;
        r.rw       = rw;
        r.mw       = mw;
        r.wb       = wb;
        r.size     = size;
        r.ack      = ack;
        r.rdata    = rdata;
        return r;
    endfunction

    initial begin
        // alu, rs2, rd, rw, mw, wb, size, ack, rdata | req, we, be, wdata, stall | rw, rd, alu, rdata, wb, mis
        vecs[0]  = '{32'h100, 32'h0, 5'd5, 1'b1, 1'b0, 2'b01, 3'b010, 1'b1, 32'hDEADBEEF,
                     1'b1, 1'b0, 4'b1111, 32'h0, 1'b0, 1'b1, 5'd5, 32'h100, 32'hDEADBEEF, 2'b01, 1'b0};
        vecs[1]  = '{32'h103, 32'h0, 5'd6, 1'b1, 1'b0, 2'b01, 3'b000, 1'b1, 32'h80FF0000,
                     1'b1, 1'b0, 4'b1000, 32'h0, 1'b0, 1'b1, 5'd6, 32'h103, 32'hFFFFFF80, 2'b01, 1'b0};
        vecs[2]  = '{32'h103, 32'h0, 5'd6, 1'b1, 1'b0, 2'b01, 3'b100, 1'b1, 32'h80FF0000,
                     1'b1, 1'b0, 4'b1000, 32'h0, 1'b0, 1'b1, 5'd6, 32'h103, 32'h00000080, 2'b01, 1'b0};
        vecs[3]  = '{32'h102, 32'h0, 5'd10, 1'b1, 1'b0, 2'b01, 3'b001, 1'b1, 32'h80011234,
                     1'b1, 1'b0, 4'b1100, 32'h0, 1'b0, 1'b1, 5'd10, 32'h102, 32'hFFFF8001, 2'b01, 1'b0};
        vecs[4]  = '{32'h102, 32'h0, 5'd10, 1'b1, 1'b0, 2'b01, 3'b101, 1'b1, 32'h80011234,
                     1'b1, 1'b0, 4'b1100, 32'h0, 1'b0, 1'b1, 5'd10, 32'h102, 32'h00008001, 2'b01, 1'b0};
        vecs[5]  = '{32'h201, 32'h123456AB, 5'd0, 1'b0, 1'b1, 2'b00, 3'b000, 1'b1, 32'h0,
                     1'b1, 1'b1, 4'b0010, 32'hABABABAB, 1'b0, 1'b0, 5'd0, 32'h201, 32'h0, 2'b00, 1'b0};
        vecs[6]  = '{32'h204, 32'hCAFEF00D, 5'd0, 1'b0, 1'b1, 2'b00, 3'b010, 1'b1, 32'h0,
                     1'b1, 1'b1, 4'b1111, 32'hCAFEF00D, 1'b0, 1'b0, 5'd0, 32'h204, 32'h0, 2'b00, 1'b0};
        vecs[7]  = '{32'h55, 32'h0, 5'd7, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 32'h0,
                     1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b1, 5'd7, 32'h55, 32'h0, 2'b00, 1'b0};
        vecs[8]  = '{32'h101, 32'h0, 5'd8, 1'b1, 1'b0, 2'b01, 3'b010, 1'b0, 32'h0,
                     1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 5'd8, 32'h101, 32'h0, 2'b01, 1'b1};
        vecs[9]  = '{32'h1004, 32'h0, 5'd1, 1'b1, 1'b0, 2'b10, 3'b000, 1'b0, 32'h0,
                     1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b1, 5'd1, 32'h1004, 32'h0, 2'b10, 1'b0};
        vecs[10] = '{32'h100, 32'h0, 5'd3, 1'b1, 1'b0, 2'b01, 3'b000, 1'b1, 32'h0000007F,
                     1'b1, 1'b0, 4'b0001, 32'h0, 1'b0, 1'b1, 5'd3, 32'h100, 32'h0000007F, 2'b01, 1'b0};
        vecs[11] = '{32'h100, 32'h0, 5'd4, 1'b1, 1'b0, 2'b01, 3'b011, 1'b0, 32'h0,
                     1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 5'd4, 32'h100, 32'h0, 2'b01, 1'b1};
        vecs[12] = '{32'h200, 32'h0000BEEF, 5'd0, 1'b0, 1'b1, 2'b00, 3'b001, 1'b1, 32'h0,
                     1'b1, 1'b1, 4'b0011, 32'hBEEFBEEF, 1'b0, 1'b0, 5'd0, 32'h200, 32'h0, 2'b00, 1'b0};
        vecs[13] = '{32'h77, 32'h0, 5'd9, 1'b1, 1'b0, 2'b00, 3'b000, 1'b1, 32'hFFFFFFFF,
                     1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b1, 5'd9, 32'h77, 32'h0, 2'b00, 1'b0};

        // Reset state
        rst = 1'b1;
        applyStimulus(mkOp(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 32'h0));
        tick();
        tick();
        checkOutput("rst_req", 32'(dmemBus.dmem_req), 32'h0);
        checkOutput("rst_stall", 32'(stall), 32'h0);
        checkRegsZero("rst");
        rst = 1'b0;

        // Zero-wait vectors
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d_req", i), 32'(dmemBus.dmem_req), 32'(vecs[i].expReq));
            checkOutput($sformatf("v%0d_we", i), 32'(dmemBus.dmem_we), 32'(vecs[i].expWe));
            checkOutput($sformatf("v%0d_be", i), 32'(dmemBus.dmem_be), 32'(vecs[i].expBe));
            checkOutput($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].expStall));
            checkOutput($sformatf("v%0d_fwd", i), forward_mem, vecs[i].alu);
            if (vecs[i].mw) begin
                checkOutput($sformatf("v%0d_wdata", i), dmemBus.dmem_wdata, vecs[i].expWdata);
                checkOutput($sformatf("v%0d_addr", i), dmemBus.dmem_addr, {vecs[i].alu[31:2], 2'b00});
            end
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d_rw", i), 32'(reg_write_out), 32'(vecs[i].expRw));
            checkOutput($sformatf("v%0d_rd", i), 32'(rd_addr_out), 32'(vecs[i].expRd));
            checkOutput($sformatf("v%0d_alu", i), alu_result_out, vecs[i].expAlu);
            checkOutput($sformatf("v%0d_rdata", i), mem_rdata_out, vecs[i].expRdata);
            checkOutput($sformatf("v%0d_wb", i), 32'(wb_mux_out), 32'(vecs[i].expWb));
            checkOutput($sformatf("v%0d_mis", i), 32'(misaligned_out), 32'(vecs[i].expMis));
        end

        // SH 0x202 with ack on the fourth request cycle
        v = mkOp(32'h202, 32'h1234ABCD, 5'd0, 1'b0, 1'b1, 2'b00, 3'b001, 1'b0, 32'h0);
        applyStimulus(v);
        for (int c = 0; c < 4; c++) begin
            dmemBus.dmem_ack = (c == 3);
            #1;
            checkOutput($sformatf("sh_c%0d_req", c), 32'(dmemBus.dmem_req), 32'h1);
            checkOutput($sformatf("sh_c%0d_be", c), 32'(dmemBus.dmem_be), 32'hC);
            checkOutput($sformatf("sh_c%0d_wdata", c), dmemBus.dmem_wdata, 32'hABCDABCD);
            checkOutput($sformatf("sh_c%0d_stall", c), 32'(stall), (c == 3) ? 32'h0 : 32'h1);
            @(posedge clk);
            #1;
            checkOutput($sformatf("sh_c%0d_rw", c), 32'(reg_write_out), 32'h0);
        end
        checkOutput("sh_alu_out", alu_result_out, 32'h202);

        // LW with one wait state: bubble first, then the load completes
        v = mkOp(32'h108, 32'h0, 5'd9, 1'b1, 1'b0, 2'b01, 3'b010, 1'b0, 32'h0);
        applyStimulus(v);
        #1;
        checkOutput("lww_stall0", 32'(stall), 32'h1);
        tick();
        checkOutput("lww_bubble_rw", 32'(reg_write_out), 32'h0);
        checkOutput("lww_bubble_wb", 32'(wb_mux_out), 32'h0);
        dmemBus.dmem_ack   = 1'b1;
        dmemBus.dmem_rdata = 32'h5A5A0F0F;
        #1;
        checkOutput("lww_stall1", 32'(stall), 32'h0);
        tick();
        checkOutput("lww_rw", 32'(reg_write_out), 32'h1);
        checkOutput("lww_rd", 32'(rd_addr_out), 32'd9);
        checkOutput("lww_rdata", mem_rdata_out, 32'h5A5A0F0F);

        // Reset asserted while waiting aborts the request immediately
        v = mkOp(32'h100, 32'h0, 5'd5, 1'b1, 1'b0, 2'b01, 3'b010, 1'b0, 32'h0);
        applyStimulus(v);
        tick();
        checkOutput("rstw_req_wait", 32'(dmemBus.dmem_req), 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("rstw_req_gated", 32'(dmemBus.dmem_req), 32'h0);
        checkOutput("rstw_stall_gated", 32'(stall), 32'h0);
        tick();
        rst = 1'b0;
        applyStimulus(mkOp(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 32'h0));
        #1;
        checkOutput("rstw_req_idle", 32'(dmemBus.dmem_req), 32'h0);
        checkOutput("rstw_stall_idle", 32'(stall), 32'h0);
        checkRegsZero("rstw");
        tick();

`ifdef MEM_STAGE_TIMEOUT_EN
        // Ack never arrives: request drops after four wait cycles
        v = mkOp(32'h300, 32'h0, 5'd12, 1'b1, 1'b0, 2'b01, 3'b010, 1'b0, 32'h0);
        applyStimulus(v);
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput($sformatf("to_c%0d_req", c), 32'(dmemBus.dmem_req), 32'h1);
            @(posedge clk);
        end
        #1;
        checkOutput("to_req_drop", 32'(dmemBus.dmem_req), 32'h0);
        checkOutput("to_stall_drop", 32'(stall), 32'h0);
        tick();
        checkOutput("to_berr", 32'(bus_error_out), 32'h1);
        checkOutput("to_rw", 32'(reg_write_out), 32'h0);
        applyStimulus(mkOp(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1, 32'h0));
        #1;
        checkOutput("to_stray_ack_req", 32'(dmemBus.dmem_req), 32'h0);
        tick();
        checkOutput("to_berr_pulse", 32'(bus_error_out), 32'h0);
`else
        // No timeout: WAIT persists until the ack finally arrives
        v = mkOp(32'h300, 32'h0, 5'd11, 1'b1, 1'b0, 2'b01, 3'b010, 1'b0, 32'h0);
        applyStimulus(v);
        for (int c = 0; c < 20; c++) begin
            #1;
            checkOutput($sformatf("nt_c%0d_stall", c), 32'(stall), 32'h1);
            @(posedge clk);
            #1;
            checkOutput($sformatf("nt_c%0d_berr", c), 32'(bus_error_out), 32'h0);
        end
        dmemBus.dmem_ack   = 1'b1;
        dmemBus.dmem_rdata = 32'h11223344;
        #1;
        checkOutput("nt_stall_end", 32'(stall), 32'h0);
        tick();
        checkOutput("nt_rw", 32'(reg_write_out), 32'h1);
        checkOutput("nt_rdata", mem_rdata_out, 32'h11223344);
        applyStimulus(mkOp(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 32'h0));
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
